mmap_read_arbiter: RTL and testbench

- Shares one async_mmap read port (read_addr push / read_data pop) among NumPorts requesters.
- Round-robin grant with bounded run length, so each requester's sequential addresses stay contiguous for downstream burst detection.
- An internal tag FIFO records the owner of every outstanding read; returning data is routed back to that owner in order.
- Sits between user kernels and async_mmap.

---
 rtl/mmap_read_arbiter.sv | 133 +++++++++++++
 tb/tb_mmap_read_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmap_read_arbiter.sv
// Round-robin arbiter sharing one async_mmap read port among NumPorts requesters.
// A tag FIFO records the owner of each outstanding read so responses route back in issue order.
//
// state   | meaning
// IDLE    | no grant; pick next requester scanning from rr_ptr
// GRANTED | grant_q owns the address channel for up to MaxRun accepts
module mmap_read_arbiter #(
  parameter int NumPorts       = 4,
  parameter int PortIdWidth    = 2,
  parameter int AddrWidth      = 64,
  parameter int DataWidth      = 512,
  parameter int MaxOutstanding = 64,
  parameter int OutstandingLog = 6,
  parameter int MaxRun         = 16,
  parameter int RunWidth       = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumPorts*AddrWidth-1:0] req_addr_din,
  input  logic [NumPorts-1:0]           req_addr_write,
  output logic [NumPorts-1:0]           req_addr_full_n,
  output logic [DataWidth-1:0]          resp_data_dout,
  output logic [NumPorts-1:0]           resp_data_empty_n,
  input  logic [NumPorts-1:0]           resp_data_read,
  output logic [AddrWidth-1:0]          read_addr_din,
  output logic                          read_addr_write,
  input  logic                          read_addr_full_n,
  input  logic [DataWidth-1:0]          read_data_dout,
  input  logic                          read_data_empty_n,
  output logic                          read_data_read,
  output logic [OutstandingLog:0]       outstanding
);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                    state_q, state_d;
  logic [PortIdWidth-1:0]    grant_q, grant_d;
  logic [PortIdWidth-1:0]    rr_ptr_q, rr_ptr_d;
  logic [RunWidth-1:0]       run_cnt_q, run_cnt_d;
  logic [PortIdWidth-1:0]    tag_mem [MaxOutstanding];
  logic [OutstandingLog-1:0] wr_ptr_q, rd_ptr_q;
  logic [OutstandingLog:0]   count_q;
  logic [PortIdWidth-1:0]    pick, head;
  logic                      any_req, tag_not_full, tag_not_empty, can_issue, accept, pop;

  assign tag_not_full  = (count_q != (OutstandingLog+1)'(MaxOutstanding));
  assign tag_not_empty = (count_q != '0);
  assign can_issue     = read_addr_full_n && tag_not_full;
  assign head          = tag_mem[rd_ptr_q];
  assign outstanding   = count_q;
  assign read_addr_din = req_addr_din[grant_q*AddrWidth +: AddrWidth];
  assign read_addr_write = accept;

  // Reverse scan so the candidate closest to rr_ptr is the one left in pick.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (req_addr_write[PortIdWidth'((int'(rr_ptr_q) + i) % NumPorts)]) begin
        pick    = PortIdWidth'((int'(rr_ptr_q) + i) % NumPorts);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    rr_ptr_d        = rr_ptr_q;
    run_cnt_d       = run_cnt_q;
    req_addr_full_n = '0;
    accept          = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = GRANTED;
          grant_d   = pick;
          run_cnt_d = '0;
        end
      end
      GRANTED: begin
        req_addr_full_n[grant_q] = can_issue;
        accept = req_addr_write[grant_q] && can_issue;
        if ((accept && run_cnt_q == RunWidth'(MaxRun - 1)) || !req_addr_write[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == PortIdWidth'(NumPorts - 1)) ? '0 : grant_q + 1'b1;
        end else if (accept) begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_data_empty_n       = '0;
    resp_data_empty_n[head] = read_data_empty_n && tag_not_empty;
    pop                     = resp_data_read[head] && read_data_empty_n && tag_not_empty;
  end

  assign read_data_read = pop;
  assign resp_data_dout = read_data_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      run_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      run_cnt_q <= run_cnt_d;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tag storage needs no reset; entries are only read while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr_q] <= grant_q;
  end

endmodule

// File: tb/tb_mmap_read_arbiter.sv
// Directed bench for mmap_read_arbiter: address and response scoreboards fed at stimulus time,
// checked by a negedge monitor as the DUT issues reads and returns data.
module tb_mmap_read_arbiter;
  localparam int NP = 4, AW = 64, DW = 512, MO = 64, OL = 6;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic [NP*AW-1:0] req_addr_din = '0;
  logic [NP-1:0]    req_addr_write = '0, resp_data_read = '0;
  logic [NP-1:0]    req_addr_full_n, resp_data_empty_n;
  logic [DW-1:0]    resp_data_dout, read_data_dout;
  logic [AW-1:0]    read_addr_din;
  logic             read_addr_write, read_data_read;
  logic             read_addr_full_n = 1'b1, read_data_empty_n = 1'b0;
  logic [OL:0]      outstanding;

  typedef struct { int port; logic [DW-1:0] data; } rsp_t;
  logic [AW-1:0] exp_addr[$];
  rsp_t          exp_rsp[$];
  int n_assert = 0, n_fail = 0, issue_idx = 0, pop_cnt = 0;

  mmap_read_arbiter #(.NumPorts(NP), .PortIdWidth(2), .AddrWidth(AW), .DataWidth(DW),
    .MaxOutstanding(MO), .OutstandingLog(OL), .MaxRun(16), .RunWidth(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_addr_din(req_addr_din), .req_addr_write(req_addr_write),
    .req_addr_full_n(req_addr_full_n), .resp_data_dout(resp_data_dout),
    .resp_data_empty_n(resp_data_empty_n), .resp_data_read(resp_data_read),
    .read_addr_din(read_addr_din), .read_addr_write(read_addr_write),
    .read_addr_full_n(read_addr_full_n), .read_data_dout(read_data_dout),
    .read_data_empty_n(read_data_empty_n), .read_data_read(read_data_read),
    .outstanding(outstanding));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dat(int k);
    return {16{32'hDA7A0000 + 32'(k)}};
  endfunction

  function automatic logic [AW-1:0] mk(int p, int j);
    return (AW'(p) << 16) + AW'(64 * j);
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    req_addr_din[p*AW +: AW] = a;
  endtask

  task automatic push_exp(input int p, input logic [AW-1:0] a);
    rsp_t r;
    r.port = p;
    r.data = dat(issue_idx);
    exp_addr.push_back(a);
    exp_rsp.push_back(r);
    issue_idx++;
  endtask

  task automatic issue(input int p, input logic [AW-1:0] base, input int n, output int cyc);
    int k;
    bit acc;
    k = 0;
    cyc = 0;
    set_addr(p, base);
    push_exp(p, base);
    req_addr_write[p] = 1'b1;
    while (k < n && cyc < 400) begin
      @(negedge clk);
      acc = req_addr_write[p] && req_addr_full_n[p];
      tick();
      cyc++;
      if (acc) begin
        k++;
        if (k < n) begin
          set_addr(p, base + AW'(64 * k));
          push_exp(p, base + AW'(64 * k));
        end
      end
    end
    req_addr_write[p] = 1'b0;
    if (k < n) chk("issue_timeout", DW'(k), DW'(n));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    read_data_empty_n = 1'b1;
    resp_data_read = '1;
    while (outstanding != 0 && cyc < 300) begin
      tick();
      cyc++;
    end
    read_data_empty_n = 1'b0;
    resp_data_read = '0;
    chk("drain_outstanding", DW'(outstanding), DW'(0));
  endtask

  // Returned data for the k-th pop since time zero is dat(k); updated just after each edge.
  always @(posedge clk) begin
    #1;
    read_data_dout = dat(pop_cnt);
  end

  always @(negedge clk) begin
    logic [AW-1:0] a;
    rsp_t r;
    if (rst_n) begin
      if (read_addr_write) begin
        if (exp_addr.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL addr_unexpected observed=%0h expected=none", read_addr_din);
        end else begin
          a = exp_addr.pop_front();
          chk("read_addr_din", DW'(read_addr_din), DW'(a));
        end
      end
      if (read_data_read) begin
        pop_cnt++;
        if (exp_rsp.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL resp_unexpected observed=%0h expected=none", resp_data_empty_n);
        end else begin
          r = exp_rsp.pop_front();
          chk("resp_port", DW'(resp_data_empty_n), DW'(NP'(1) << r.port));
          chk("resp_data", resp_data_dout, r.data);
        end
      end
    end
  end

  initial begin
    int cyc, total;
    int cnt[NP];
    bit acc[NP];

    // Reset state
    #2;
    chk("rst_full_n", DW'(req_addr_full_n), DW'(0));
    chk("rst_empty_n", DW'(resp_data_empty_n), DW'(0));
    chk("rst_addr_write", DW'(read_addr_write), DW'(0));
    chk("rst_data_read", DW'(read_data_read), DW'(0));
    chk("rst_outstanding", DW'(outstanding), DW'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fairness: all ports request continuously with data returning every cycle
    for (int r = 0; r < 5; r++)
      for (int j = 0; j < 16; j++) push_exp(r % NP, mk(r % NP, (r / NP) * 16 + j));
    for (int p = 0; p < NP; p++) begin
      cnt[p] = 0;
      set_addr(p, mk(p, 0));
    end
    total = 0;
    read_data_empty_n = 1'b1;
    resp_data_read = '1;
    req_addr_write = '1;
    repeat (85) begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) acc[p] = req_addr_write[p] && req_addr_full_n[p];
      tick();
      for (int p = 0; p < NP; p++)
        if (acc[p]) begin
          cnt[p]++;
          total++;
          set_addr(p, mk(p, cnt[p]));
        end
    end
    req_addr_write = '0;
    chk("fair_total", DW'(total), DW'(80));
    chk("fair_p0", DW'(cnt[0]), DW'(32));
    chk("fair_p1", DW'(cnt[1]), DW'(16));
    chk("fair_p2", DW'(cnt[2]), DW'(16));
    chk("fair_p3", DW'(cnt[3]), DW'(16));
    drain();

    // Single port streaming
    issue(1, 64'h1000, 3, cyc);
    chk("stream_cycles", DW'(cyc), DW'(4));
    chk("stream_outstanding", DW'(outstanding), DW'(3));
    drain();

    // Routing: port2 then port0, responses in issue order
    issue(2, 64'hA000, 1, cyc);
    issue(0, 64'hB000, 1, cyc);
    chk("route_outstanding", DW'(outstanding), DW'(2));
    read_data_empty_n = 1'b1;
    resp_data_read = '0;
    @(negedge clk);
    chk("route_head_port2", DW'(resp_data_empty_n), DW'(4'b0100));
    chk("route_head_data", resp_data_dout, exp_rsp[0].data);
    resp_data_read = 4'b0001;
    @(negedge clk);
    chk("route_nonhead_ignored", DW'(read_data_read), DW'(0));
    tick();
    chk("route_no_pop", DW'(outstanding), DW'(2));
    drain();

    // Backpressure from async_mmap while port 3 holds the grant
    read_addr_full_n = 1'b0;
    set_addr(3, 64'hC000);
    push_exp(3, 64'hC000);
    req_addr_write[3] = 1'b1;
    tick();
    repeat (5) begin
      @(negedge clk);
      chk("bp_full_n", DW'(req_addr_full_n), DW'(0));
      chk("bp_addr_write", DW'(read_addr_write), DW'(0));
      tick();
      chk("bp_outstanding", DW'(outstanding), DW'(0));
    end
    read_addr_full_n = 1'b1;
    @(negedge clk);
    chk("bp_resume_port3", DW'(req_addr_full_n), DW'(4'b1000));
    tick();
    req_addr_write[3] = 1'b0;
    chk("bp_accepted", DW'(outstanding), DW'(1));
    drain();

    // Tag FIFO full
    issue(0, 64'h10000, 64, cyc);
    chk("full_outstanding", DW'(outstanding), DW'(64));
    set_addr(1, 64'h20000);
    push_exp(1, 64'h20000);
    req_addr_write[1] = 1'b1;
    tick();
    @(negedge clk);
    chk("full_full_n", DW'(req_addr_full_n), DW'(0));
    tick();
    read_data_empty_n = 1'b1;
    resp_data_read = 4'b0001;
    @(negedge clk);
    chk("full_pop", DW'(read_data_read), DW'(1));
    tick();
    chk("full_after_pop", DW'(outstanding), DW'(63));
    @(negedge clk);
    chk("full_reopen", DW'(req_addr_full_n), DW'(4'b0010));
    tick();
    chk("simul_push_pop", DW'(outstanding), DW'(63));
    set_addr(1, 64'h20040);
    push_exp(1, 64'h20040);
    read_data_empty_n = 1'b0;
    resp_data_read = '0;
    tick();
    req_addr_write[1] = 1'b0;
    chk("full_again", DW'(outstanding), DW'(64));
    drain();

    // Async reset mid-run
    issue(2, 64'h30000, 5, cyc);
    chk("rst_pre_outstanding", DW'(outstanding), DW'(5));
    read_addr_full_n = 1'b0;
    req_addr_write[2] = 1'b1;
    read_data_empty_n = 1'b1;
    @(negedge clk);
    chk("rst_pre_empty_n", DW'(resp_data_empty_n), DW'(4'b0100));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_empty_n", DW'(resp_data_empty_n), DW'(0));
    chk("arst_full_n", DW'(req_addr_full_n), DW'(0));
    chk("arst_data_read", DW'(read_data_read), DW'(0));
    chk("arst_outstanding", DW'(outstanding), DW'(0));
    exp_addr.delete();
    exp_rsp.delete();
    issue_idx = pop_cnt;
    req_addr_write = '0;
    read_data_empty_n = 1'b0;
    read_addr_full_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    set_addr(1, 64'h40000);
    set_addr(3, 64'h50000);
    push_exp(1, 64'h40000);
    req_addr_write = 4'b1010;
    tick();
    @(negedge clk);
    chk("rr_after_reset", DW'(req_addr_full_n), DW'(4'b0010));
    tick();
    req_addr_write = '0;
    drain();

    chk("addr_queue_empty", DW'(exp_addr.size()), DW'(0));
    chk("rsp_queue_empty", DW'(exp_rsp.size()), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
